// File: rtl/sr_cmd_pkg.sv
// ---------------------------------------------------------------------------
// sr_cmd_pkg
// Shared types and constants for the SR command generator:
//   - FSM state encoding used by sr_cmd_generator
//   - pending-slot type encoding and the pending-slot struct
//   - default debounce length / counter width
// ---------------------------------------------------------------------------
package sr_cmd_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    GAP   = 2'd3
  } sr_state_e;

  typedef enum logic {
    PEND_CLR = 1'b0,
    PEND_SET = 1'b1
  } sr_pend_e;

  // One-deep pending slot: valid bit plus the event type it holds.
  typedef struct packed {
    logic     vld;
    sr_pend_e typ;
  } sr_pend_t;

  // Pulse state that services a given event type.
  function automatic sr_state_e pend_state(sr_pend_e t);
    return (t == PEND_SET) ? SET_P : CLR_P;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// ---------------------------------------------------------------------------
// sr_debounce
// Two-flop synchroniser, debounce counter and accepted (stable) level for one
// raw request line. Emits a one-cycle rise event when the stable level goes
// 0 -> 1; falling edges are absorbed silently.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-low reset
//   raw_i   in   raw asynchronous, bouncy request
//   rise_o  out  one-cycle pulse on the rising edge of the stable level
//
// A new synchronised level must differ from the stable level for DEB_CYCLES
// consecutive cycles before it is accepted. DEB_CYCLES must be 2..15 and
// 2**CNT_W must exceed DEB_CYCLES.
// ---------------------------------------------------------------------------
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the
  // accepted level; any agreement (glitch reverted) or an acceptance
  // leaves it at zero.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      meta_q       <= raw_i;
      sync_q       <= meta_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign rise_o = stable_q & ~stable_dly_q;

endmodule

// File: rtl/sr_cmd_generator.sv
// ---------------------------------------------------------------------------
// sr_cmd_generator
// Turns raw set/clear request lines into clean, mutually exclusive
// single-cycle S/R pulses for downstream SR-style flip-flops.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-low reset
//   set_req_in  in   raw set request (async, may bounce)
//   clr_req_in  in   raw clear request (async, may bounce)
//   S           out  registered one-cycle set pulse
//   R           out  registered one-cycle reset pulse
//   busy        out  registered, high in SET_P / CLR_P / GAP
//   conflict    out  registered one-cycle flag: set and clear events coincided
//
// Build option:
//   SR_SET_PRIORITY_EN  defined   -> on coinciding events set wins
//                       undefined -> coinciding events are both dropped
//   conflict is raised in either build.
//
// Every pulse is followed by a GAP cycle and an IDLE cycle, so pulses are at
// least 3 cycles apart and S/R can never be high together. Events arriving
// while busy land in a one-deep pending slot (most recent wins) that is
// serviced from IDLE.
// ---------------------------------------------------------------------------
module sr_cmd_generator
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req_in,
  input  logic clr_req_in,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

  logic      set_ev, clr_ev;
  logic      eff_set, eff_clr;
  logic      new_ev;
  sr_pend_e  new_typ;

  sr_state_e state_q, state_d;
  sr_pend_t  pend_q, pend_d;
  logic      s_q, r_q, busy_q, conflict_q;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_set (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (set_req_in),
    .rise_o (set_ev)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_clr (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (clr_req_in),
    .rise_o (clr_ev)
  );

  // Conflict resolution: collapse the two raw events into at most one
  // effective event before it reaches the FSM / pending slot.
`ifdef SR_SET_PRIORITY_EN
  assign eff_set = set_ev;
  assign eff_clr = clr_ev & ~set_ev;
`else
  assign eff_set = set_ev & ~clr_ev;
  assign eff_clr = clr_ev & ~set_ev;
`endif

  assign new_ev  = eff_set | eff_clr;
  assign new_typ = eff_set ? PEND_SET : PEND_CLR;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q.vld) begin
          // Serve the stored event; a fresh event this cycle takes its
          // place since the FSM is about to go busy.
          state_d    = pend_state(pend_q.typ);
          pend_d.vld = new_ev;
          pend_d.typ = new_typ;
        end else if (new_ev) begin
          state_d = pend_state(new_typ);
        end
      end
      SET_P, CLR_P: begin
        state_d = GAP;
        if (new_ev) begin
          pend_d.vld = 1'b1;
          pend_d.typ = new_typ;
        end
      end
      GAP: begin
        state_d = IDLE;
        if (new_ev) begin
          pend_d.vld = 1'b1;
          pend_d.typ = new_typ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register rather than trailing it by a cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      s_q        <= (state_d == SET_P);
      r_q        <= (state_d == CLR_P);
      busy_q     <= (state_d != IDLE);
      conflict_q <= set_ev & clr_ev;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_generator.sv
`timescale 1ns/1ps
module tb_sr_cmd_generator;

  localparam int DEB  = 4;
  localparam int MAXC = 8000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_raw = 1'b0;
  logic clr_raw = 1'b0;
  logic S, R, busy, conflict;

  sr_cmd_generator #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .set_req_in (set_raw),
    .clr_req_in (clr_raw),
    .S          (S),
    .R          (R),
    .busy       (busy),
    .conflict   (conflict)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (edge-indexed histories) --------------
  // raw_h[k][n] : raw input k sampled at edge n (k=0 set, k=1 clr)
  // syn_h[k][n] : synchronised value visible after edge n
  // stb_h[k][n] : accepted level after edge n
  bit raw_h [2][MAXC];
  bit syn_h [2][MAXC];
  bit stb_h [2][MAXC];
  bit rst_h [MAXC];
  bit busy_exp [MAXC];

  typedef struct { int cyc; bit s; bit r; bit c; } exp_t;
  exp_t expq[$];

  int n_edge  = 0;
  int free_at = 0;   // first edge at which a new pulse may start
  bit pend_v  = 0;
  bit pend_s  = 0;

  int tests = 0;
  int fails = 0;

  always @(posedge clk) begin
    int n;
    bit ev [2];
    bit eff_s, eff_c, ps, pr, pc, pb;
    exp_t e;
    n = n_edge + 1;
    if (n < MAXC) begin
      raw_h[0][n] = set_raw;
      raw_h[1][n] = clr_raw;
      rst_h[n]    = !rst_n;
      ps = 0; pr = 0; pc = 0; pb = 0;
      if (rst_h[n]) begin
        for (int k = 0; k < 2; k++) begin
          syn_h[k][n] = 0;
          stb_h[k][n] = 0;
        end
        free_at = n + 1;
        pend_v  = 0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          bit old, run;
          syn_h[k][n] = rst_h[n-1] ? 1'b0 : raw_h[k][n-1];
          // accepted level flips once the last DEB synchronised samples
          // all disagree with it
          old = stb_h[k][n-1];
          run = 1;
          for (int j = 1; j <= DEB; j++)
            if (n - j < 1 || syn_h[k][n-j] == old) run = 0;
          stb_h[k][n] = run ? !old : old;
          ev[k] = (n >= 2) && stb_h[k][n-1] && !stb_h[k][n-2];
        end
        pc = ev[0] & ev[1];
`ifdef SR_SET_PRIORITY_EN
        eff_s = ev[0];
`else
        eff_s = ev[0] & !ev[1];
`endif
        eff_c = ev[1] & !ev[0];
        if (n >= free_at) begin
          if (pend_v) begin
            ps = pend_s; pr = !pend_s;
            pend_v = eff_s | eff_c;
            pend_s = eff_s;
            free_at = n + 3;
          end else if (eff_s | eff_c) begin
            ps = eff_s; pr = eff_c;
            free_at = n + 3;
          end
        end else if (eff_s | eff_c) begin
          pend_v = 1;
          pend_s = eff_s;
        end
        pb = (n < free_at - 1);
      end
      busy_exp[n] = pb;
      if (ps | pr | pc) begin
        e.cyc = n; e.s = ps; e.r = pr; e.c = pc;
        expq.push_back(e);
      end
    end
    n_edge = n;
  end

  // ---------------- monitor / scoreboard ----------------------------------
  always @(negedge clk) begin
    int n;
    exp_t e;
    n = n_edge;
    if (n >= 1 && n < MAXC) begin
      tests++;
      if (busy !== busy_exp[n]) begin
        fails++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", n, busy, busy_exp[n]);
      end
      tests++;
      if (S === 1'b1 && R === 1'b1) begin
        fails++;
        $display("FAIL s_and_r cyc=%0d got=S1R1 exp=not both", n);
      end
      while (expq.size() > 0 && expq[0].cyc < n) begin
        e = expq.pop_front();
        tests++;
        fails++;
        $display("FAIL missed_pulse cyc=%0d got=none exp=S%bR%bC%b", e.cyc, e.s, e.r, e.c);
      end
      if (S !== 1'b0 || R !== 1'b0 || conflict !== 1'b0) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse cyc=%0d got=S%bR%bC%b exp=none", n, S, R, conflict);
        end else begin
          e = expq.pop_front();
          if (e.cyc != n || e.s !== S || e.r !== R || e.c !== conflict) begin
            fails++;
            $display("FAIL pulse cyc=%0d got=S%bR%bC%b exp=cyc%0d S%bR%bC%b",
                     n, S, R, conflict, e.cyc, e.s, e.r, e.c);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic wait_cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic drive(bit s, bit c, bit r);
    set_raw = s;
    clr_raw = c;
    rst_n   = r;
  endtask

  task automatic chk(string nm, logic got, logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  initial begin
    int cnt [2];
    bit lvl [2];
    bit rv;

    // reset with both requests high
    drive(1, 1, 0); wait_cyc(2);
    chk("rst_S", S, 1'b0);
    chk("rst_R", R, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_conflict", conflict, 1'b0);

    // clean set, held 10+ cycles
    drive(1, 0, 1); wait_cyc(12);
    drive(0, 0, 1); wait_cyc(10);

    // clear glitch of 3 cycles (rejected) then 4 cycles (accepted)
    drive(0, 1, 1); wait_cyc(3);
    drive(0, 0, 1); wait_cyc(10);
    drive(0, 1, 1); wait_cyc(4);
    drive(0, 0, 1); wait_cyc(12);

    // back-to-back: clr one cycle behind set
    drive(1, 0, 1); wait_cyc(1);
    drive(1, 1, 1); wait_cyc(14);
    drive(0, 0, 1); wait_cyc(10);

    // simultaneous rise
    drive(1, 1, 1); wait_cyc(12);
    drive(0, 0, 1); wait_cyc(10);

    // reset during SET_P with a clear pending
    drive(1, 0, 1); wait_cyc(1);
    drive(1, 1, 1); wait_cyc(6);
    drive(0, 0, 0); wait_cyc(2);
    drive(0, 0, 1); wait_cyc(15);

    // randomized bouncy inputs with occasional resets
    cnt[0] = 0; cnt[1] = 0; lvl[0] = 0; lvl[1] = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (cnt[k] == 0) begin
          lvl[k] = !lvl[k];
          cnt[k] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(12, 5))
                                               : int'($urandom_range(4, 1));
        end else begin
          cnt[k]--;
        end
      end
      if ($urandom_range(15, 0) == 0) begin
        lvl[1] = lvl[0];
        cnt[1] = cnt[0];
      end
      rv = ($urandom_range(399, 0) != 0);
      drive(lvl[0], lvl[1], rv);
      wait_cyc(1);
    end

    // drain and make sure nothing expected is still outstanding
    drive(0, 0, 1); wait_cyc(30);
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected got=%0d exp=0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
